// File: rtl/slicer_pkg.sv
// Shared types and constants for the time-multiplexed slicer scan controller.
package slicer_pkg;

    localparam int NCH_DEFAULT = 4;
    localparam int PULSE_CW    = 8;
    localparam int SETTLE_CW   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SETTLE,
        ST_SAMPLE,
        ST_ADVANCE
    } state_t;

endpackage

// File: rtl/slicer_scan_ctrl_if.sv
// Per-channel configuration write port (valid/ready) of the slicer scan controller.
interface slicer_scan_ctrl_if #(
    parameter int NCH = slicer_pkg::NCH_DEFAULT
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [$clog2(NCH)-1:0] cfg_ch;
    logic [7:0]             cfg_vref;
    logic [7:0]             cfg_width;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_vref,
        output cfg_width,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_vref,
        input  cfg_width,
        output cfg_ready
    );
endinterface

// File: rtl/slicer_pulse_gen.sv
// One-shot pulse stretcher for a single slicer channel; a load is ignored while
// a pulse is already running, so detections cannot retrigger it.
module slicer_pulse_gen
    import slicer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [PULSE_CW-1:0] i_width,
    output logic                o_dout
);

    logic [PULSE_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end else if (i_load && (i_width != '0)) begin
            r_cnt <= i_width;
        end
    end

    assign o_dout = (r_cnt != '0);

endmodule

// File: rtl/slicer_scan_ctrl.sv
// Round-robin scan of NCH slicer channels through one shared comparator/DAC,
// with rising-level detection stretched into per-channel fixed-width pulses.
module slicer_scan_ctrl
    import slicer_pkg::*;
#(
    parameter int         NCH        = NCH_DEFAULT,
    parameter int         SETTLE_CYC = 4,
    parameter logic [7:0] VREF_RST   = 8'h80,
    parameter logic [7:0] WIDTH_RST  = 8'd16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    slicer_scan_ctrl_if.slave      cfg,
    output logic [$clog2(NCH)-1:0] ch_sel,
    output logic [7:0]             dac_code,
    input  logic                   cmp_in,
    output logic [NCH-1:0]         dout,
    output logic                   busy
);

    localparam int CHW = $clog2(NCH);

    state_t               r_state;
    state_t               w_state_next;
    logic [CHW-1:0]       r_ptr;
    logic [SETTLE_CW-1:0] r_settle;
    logic [CHW-1:0]       r_ch_sel;
    logic [7:0]           r_dac_code;
    logic [NCH-1:0]       r_level;
    logic [7:0]           w_vref  [NCH];
    logic [7:0]           w_width [NCH];
    logic [NCH-1:0]       w_load;
    logic                 w_ptr_locked;
    logic                 w_cfg_we;
    logic                 w_is_setup;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        w_ptr_locked = 1'b0;
        w_is_setup   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (en) w_state_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_ptr_locked = 1'b1;
                w_is_setup   = 1'b1;
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_ptr_locked = 1'b1;
                if (r_settle == '0) w_state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                w_ptr_locked = 1'b1;
                w_state_next = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                w_state_next = en ? ST_SETUP : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The active channel's entry is frozen from SETUP to SAMPLE so the DAC code
    // and the pulse width seen by the detector cannot change mid-measurement.
    assign cfg.cfg_ready = !(w_ptr_locked && (cfg.cfg_ch == r_ptr));
    assign w_cfg_we      = cfg.cfg_valid && cfg.cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_settle   <= '0;
            r_ch_sel   <= '0;
            r_dac_code <= VREF_RST;
            r_level    <= '0;
        end else begin
            case (r_state)
                ST_SETUP: begin
                    r_settle   <= SETTLE_CW'(SETTLE_CYC - 1);
                    r_ch_sel   <= r_ptr;
                    r_dac_code <= w_vref[r_ptr];
                end
                ST_SETTLE: begin
                    if (r_settle != '0) r_settle <= r_settle - 1'b1;
                end
                ST_SAMPLE: begin
                    r_level[r_ptr] <= cmp_in;
                end
                ST_ADVANCE: begin
                    r_ptr <= (r_ptr == CHW'(NCH - 1)) ? '0 : r_ptr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // SETUP presents the new channel in its own cycle; later states replay the
    // registered copy so the outputs hold through ADVANCE and IDLE.
    assign ch_sel   = w_is_setup ? r_ptr         : r_ch_sel;
    assign dac_code = w_is_setup ? w_vref[r_ptr] : r_dac_code;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
            logic [7:0] r_vref;
            logic [7:0] r_width;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vref  <= VREF_RST;
                    r_width <= WIDTH_RST;
                end else if (w_cfg_we && (cfg.cfg_ch == CHW'(gi))) begin
                    r_vref  <= cfg.cfg_vref;
                    r_width <= cfg.cfg_width;
                end
            end

            assign w_vref[gi]  = r_vref;
            assign w_width[gi] = r_width;
            assign w_load[gi]  = (r_state == ST_SAMPLE) && (r_ptr == CHW'(gi)) &&
                                 cmp_in && !r_level[gi];

            slicer_pulse_gen u_pulse_gen (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[gi]),
                .i_width (w_width[gi]),
                .o_dout  (dout[gi])
            );
        end
    endgenerate

endmodule
